// File: rtl/rgmii_nibble_tx_framer_if.sv
// Byte-stream handshake between the MAC/packet buffer and the RGMII nibble framer.
// master: byte source (MAC side). slave: the framer.
interface rgmii_nibble_tx_framer_if;
    logic [7:0] d;
    logic       d_valid;
    logic       d_last;
    logic       d_ready;

    modport master (output d, output d_valid, output d_last, input d_ready);
    modport slave  (input d, input d_valid, input d_last, output d_ready);
endinterface

// File: rtl/rgmii_nibble_tx_framer.sv
// RGMII 10/100 transmit framer: preamble+SFD, payload nibbles (low first),
// optional zero pad, CRC-32 FCS, then inter-frame gap. One nibble per clk.
// Build option: ETH_TX_AUTOPAD_EN adds zero padding up to MIN_FRAME_BYTES.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// S_IDLE     | waiting for d_valid, tx_en low
// S_PREAMBLE | 0x5 nibbles, then SFD 0xD; first byte accepted on SFD clk
// S_PAYLOAD  | byte out low/high nibble; next byte accepted on high nibble
// S_PAD      | 0x00 bytes up to MIN_FRAME_BYTES (autopad builds only)
// S_FCS      | 8 nibbles of ~CRC (or raw CRC after an underrun), LS first
// S_IFG      | tx_en low; together with one IDLE clk gives IFG_NIBBLES
//
// tx_d/tx_en/frame_done/underrun are registered, so they trail the state
// that produced them by one clk.
module rgmii_nibble_tx_framer #(
    parameter int PREAMBLE_NIBBLES = 15,
    parameter int MIN_FRAME_BYTES  = 60,
    parameter int IFG_NIBBLES      = 24
) (
    input  logic                           clk,
    input  logic                           rst,
    rgmii_nibble_tx_framer_if.slave        src,
    output logic [3:0]                     tx_d,
    output logic                           tx_en,
    output logic                           busy,
    output logic                           frame_done,
    output logic                           underrun
);

    typedef enum logic [2:0] {
        S_IDLE, S_PREAMBLE, S_PAYLOAD, S_PAD, S_FCS, S_IFG
    } state_t;

    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;
    localparam logic [7:0]  PRE_LOAD = 8'(PREAMBLE_NIBBLES);
    localparam logic [7:0]  FCS_LOAD = 8'd7;
    // The IDLE clk that follows IFG supplies the last idle nibble of the gap.
    localparam logic [7:0]  IFG_LOAD = 8'(IFG_NIBBLES - 2);

    state_t      state, state_nxt;
    logic [7:0]  cnt;
    logic        cnt_zero;
    logic        phase;
    logic [7:0]  cur_byte;
    logic        last_byte;
    logic        bad_fcs;
    logic [31:0] crc;
    logic [31:0] fcs_word;
    logic        d_ready;
    logic        accept;
    logic        starve;
    logic        pad_needed;
    logic        pad_end;
    logic        pad_step;
    logic [3:0]  nib;
    logic        nib_en;
    logic        done_now;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        return r;
    endfunction

    assign cnt_zero    = (cnt == 8'd0);
    assign accept      = d_ready & src.d_valid;
    assign starve      = d_ready & ~src.d_valid;
    assign src.d_ready = d_ready;
    assign busy        = (state != S_IDLE);
    assign fcs_word    = bad_fcs ? crc : ~crc;

`ifdef ETH_TX_AUTOPAD_EN
    logic [15:0] byte_cnt;

    assign pad_needed = ({16'd0, byte_cnt} < 32'(MIN_FRAME_BYTES));
    assign pad_end    = ({16'd0, byte_cnt} + 32'd1 >= 32'(MIN_FRAME_BYTES));
    assign pad_step   = (state == S_PAD) && phase;

    // Payload+pad byte count, restarted per frame, saturating.
    always_ff @(posedge clk) begin
        if (rst)
            byte_cnt <= 16'd0;
        else if (state == S_IDLE && src.d_valid)
            byte_cnt <= 16'd0;
        else if ((accept || pad_step) && byte_cnt != 16'hFFFF)
            byte_cnt <= byte_cnt + 16'd1;
    end
`else
    localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME_BYTES);
    logic unused_min_len;

    assign unused_min_len = ^MIN_LEN;
    assign pad_needed     = 1'b0;
    assign pad_end        = 1'b0;
    assign pad_step       = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:
                if (src.d_valid)
                    state_nxt = S_PREAMBLE;
            S_PREAMBLE:
                if (cnt_zero)
                    state_nxt = src.d_valid ? S_PAYLOAD : S_FCS;
            S_PAYLOAD:
                if (phase) begin
                    if (last_byte)
                        state_nxt = pad_needed ? S_PAD : S_FCS;
                    else if (!src.d_valid)
                        state_nxt = S_FCS;
                end
`ifdef ETH_TX_AUTOPAD_EN
            S_PAD:
                if (phase && pad_end)
                    state_nxt = S_FCS;
`endif
            S_FCS:
                if (cnt_zero)
                    state_nxt = S_IFG;
            S_IFG:
                if (cnt_zero)
                    state_nxt = S_IDLE;
            default:
                state_nxt = S_IDLE;
        endcase
    end

    // Per-state outputs: handshake and the nibble to register for the pins.
    always_comb begin
        d_ready  = 1'b0;
        nib      = 4'h0;
        nib_en   = 1'b0;
        done_now = 1'b0;
        case (state)
            S_PREAMBLE: begin
                nib_en  = 1'b1;
                nib     = cnt_zero ? 4'hD : 4'h5;
                d_ready = cnt_zero;
            end
            S_PAYLOAD: begin
                nib_en  = 1'b1;
                nib     = phase ? cur_byte[7:4] : cur_byte[3:0];
                d_ready = phase & ~last_byte;
            end
            S_PAD: begin
                nib_en = 1'b1;
            end
            S_FCS: begin
                nib_en   = 1'b1;
                nib      = fcs_word[{~cnt[2:0], 2'b00} +: 4];
                done_now = cnt_zero;
            end
            default: begin
                nib_en = 1'b0;
            end
        endcase
    end

    // Down-counter timers, nibble phase, current byte and running CRC.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= 8'd0;
            phase     <= 1'b0;
            cur_byte  <= 8'd0;
            last_byte <= 1'b0;
            bad_fcs   <= 1'b0;
            crc       <= CRC_INIT;
        end else begin
            if (state_nxt != state) begin
                case (state_nxt)
                    S_PREAMBLE: cnt <= PRE_LOAD;
                    S_FCS:      cnt <= FCS_LOAD;
                    S_IFG:      cnt <= IFG_LOAD;
                    default:    cnt <= 8'd0;
                endcase
            end else if (!cnt_zero) begin
                cnt <= cnt - 8'd1;
            end

            if (state == S_PAYLOAD || state == S_PAD)
                phase <= ~phase;
            else
                phase <= 1'b0;

            if (accept) begin
                cur_byte  <= src.d;
                last_byte <= src.d_last;
            end

            if (state == S_IDLE && src.d_valid) begin
                crc     <= CRC_INIT;
                bad_fcs <= 1'b0;
            end else begin
                if (accept)
                    crc <= crc_byte(crc, src.d);
                else if (pad_step)
                    crc <= crc_byte(crc, 8'h00);
                if (starve)
                    bad_fcs <= 1'b1;
            end
        end
    end

    // Registered pin drive and status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_d       <= 4'h0;
            tx_en      <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            tx_d       <= nib;
            tx_en      <= nib_en;
            frame_done <= done_now;
            underrun   <= starve;
        end
    end

endmodule

// File: tb/tb_rgmii_nibble_tx_framer.sv
// Bench for rgmii_nibble_tx_framer: vector table of frames, expected nibble
// stream queued per frame and popped as tx_en nibbles appear, plus hand
// sequences for SFD starvation, back-to-back frames and mid-frame reset.
module tb_rgmii_nibble_tx_framer;

    localparam int PRE = 15;
    localparam int MIN = 60;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] tx_d;
    logic       tx_en;
    logic       busy;
    logic       frame_done;
    logic       underrun;

    rgmii_nibble_tx_framer_if bus();

    rgmii_nibble_tx_framer #(
        .PREAMBLE_NIBBLES(PRE),
        .MIN_FRAME_BYTES(MIN),
        .IFG_NIBBLES(24)
    ) dut (
        .clk(clk),
        .rst(rst),
        .src(bus),
        .tx_d(tx_d),
        .tx_en(tx_en),
        .busy(busy),
        .frame_done(frame_done),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_q[$];
    bit         started = 1'b0;
    int         cyc = 0;
    int         fall_cyc = 0;
    int         gap = 0;
    int         en_len = 0;
    int         last_en_len = 0;
    int         done_cnt = 0;
    int         under_cnt = 0;
    logic       tx_en_q = 1'b0;

    typedef struct {
        int pattern;    // 0 ascii "1..", 1 incrementing, 2 constant 0xAB, 3 random
        int len;
        int starve_at;  // -1: none, else bytes accepted before d_valid drops
        int exp_en;
        int exp_under;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int k = 0; k < 8; k++)
            r = (r[0] ^ b[k]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // Pin monitor: compares every enabled nibble against the scoreboard.
    always @(negedge clk) begin
        cyc++;
        if (started && !rst) begin
            if (tx_en) begin
                if (!tx_en_q) begin
                    gap    = cyc - fall_cyc;
                    en_len = 0;
                end
                en_len++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL nibble: got 0x%0h with no nibble expected", tx_d);
                end else begin
                    chk("nibble", {28'd0, tx_d}, {28'd0, exp_q.pop_front()});
                end
            end else begin
                if (tx_en_q) begin
                    fall_cyc    = cyc;
                    last_en_len = en_len;
                end
                chk("idle tx_d", {28'd0, tx_d}, 32'd0);
            end
            if (frame_done) begin
                done_cnt++;
                chk("frame_done with tx_en", {31'd0, tx_en}, 32'd1);
            end
            if (underrun)
                under_cnt++;
        end
        tx_en_q = tx_en;
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy) begin
            @(negedge clk);
            n++;
            if (n > 4000) begin
                checks++;
                errors++;
                $display("FAIL idle timeout: busy still 1 after %0d clks, expected 0", n);
                return;
            end
        end
    endtask

    // Queues the expected nibbles for a frame, then drives its bytes.
    task automatic send_frame(input int pattern, input int len, input int starve_at, input int rst_at);
        logic [7:0]  b[$];
        logic [31:0] c;
        logic [3:0]  lit[8];
        int          nsent;
        int          i;
        int          guard;
        bit          fire;

        lit = '{4'h6, 4'h2, 4'h9, 4'h3, 4'h4, 4'hF, 4'hB, 4'hC};
        for (int k = 0; k < len; k++) begin
            case (pattern)
                0:       b.push_back(8'(8'h31 + k));
                1:       b.push_back(8'(k));
                2:       b.push_back(8'hAB);
                default: b.push_back(8'($urandom_range(0, 255)));
            endcase
        end
        nsent = (starve_at >= 0) ? starve_at : len;

        for (int k = 0; k < PRE; k++)
            exp_q.push_back(4'h5);
        exp_q.push_back(4'hD);
        c = 32'hFFFFFFFF;
        for (int k = 0; k < nsent; k++) begin
            exp_q.push_back(b[k][3:0]);
            exp_q.push_back(b[k][7:4]);
            c = crc_upd(c, b[k]);
        end
        if (starve_at < 0) begin
`ifdef ETH_TX_AUTOPAD_EN
            for (int k = nsent; k < MIN; k++) begin
                exp_q.push_back(4'h0);
                exp_q.push_back(4'h0);
                c = crc_upd(c, 8'h00);
            end
`endif
            c = ~c;
        end
        if (pattern == 0 && len == 9 && starve_at < 0) begin
            for (int k = 0; k < 8; k++)
                exp_q.push_back(lit[k]);
        end else begin
            for (int k = 0; k < 8; k++)
                exp_q.push_back(c[4*k +: 4]);
        end

        i = 0;
        guard = 0;
        bus.d       = b[0];
        bus.d_last  = (len == 1);
        bus.d_valid = (nsent != 0);
        while (i < nsent) begin
            @(negedge clk);
            fire = bus.d_ready && bus.d_valid;
            @(posedge clk);
            #1;
            if (fire) begin
                i++;
                if (i < nsent) begin
                    bus.d      = b[i];
                    bus.d_last = (i == len - 1);
                end
            end
            if (rst_at >= 0 && i == rst_at) begin
                rst = 1'b1;
                bus.d_valid = 1'b0;
                bus.d_last  = 1'b0;
                @(negedge clk);
                @(negedge clk);
                chk("rst tx_en", {31'd0, tx_en}, 32'd0);
                chk("rst busy", {31'd0, busy}, 32'd0);
                chk("rst d_ready", {31'd0, bus.d_ready}, 32'd0);
                exp_q.delete();
                @(posedge clk);
                #1;
                rst = 1'b0;
                return;
            end
            guard++;
            if (guard > 3000) begin
                checks++;
                errors++;
                $display("FAIL accept timeout: %0d of %0d bytes taken", i, nsent);
                break;
            end
        end
        bus.d_valid = 1'b0;
        bus.d_last  = 1'b0;
    endtask

    vec_t vecs[6];

    initial begin
        int d0;
        int u0;

`ifdef ETH_TX_AUTOPAD_EN
        vecs[0] = '{0, 9, -1, 144, 0};
        vecs[2] = '{2, 1, -1, 144, 0};
        vecs[5] = '{3, 2, -1, 144, 0};
`else
        vecs[0] = '{0, 9, -1, 42, 0};
        vecs[2] = '{2, 1, -1, 26, 0};
        vecs[5] = '{3, 2, -1, 28, 0};
`endif
        vecs[1] = '{1, 60, -1, 144, 0};
        vecs[3] = '{3, 64, -1, 152, 0};
        vecs[4] = '{3, 64, 10, 44, 1};

        bus.d = 8'h00;
        bus.d_valid = 1'b0;
        bus.d_last = 1'b0;

        fork
            begin
                #2_000_000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset tx_d", {28'd0, tx_d}, 32'd0);
        chk("reset tx_en", {31'd0, tx_en}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset d_ready", {31'd0, bus.d_ready}, 32'd0);
        chk("reset frame_done", {31'd0, frame_done}, 32'd0);
        chk("reset underrun", {31'd0, underrun}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        started = 1'b1;

        foreach (vecs[v]) begin
            d0 = done_cnt;
            u0 = under_cnt;
            send_frame(vecs[v].pattern, vecs[v].len, vecs[v].starve_at, -1);
            wait_idle();
            chk($sformatf("vec%0d tx_en clks", v), last_en_len, vecs[v].exp_en);
            chk($sformatf("vec%0d frame_done", v), done_cnt - d0, 1);
            chk($sformatf("vec%0d underrun", v), under_cnt - u0, vecs[v].exp_under);
            chk($sformatf("vec%0d queue left", v), exp_q.size(), 0);
        end

        // d_valid for one clk only: SFD clk starves, FCS is raw init CRC.
        d0 = done_cnt;
        u0 = under_cnt;
        @(posedge clk);
        #1;
        for (int k = 0; k < PRE; k++)
            exp_q.push_back(4'h5);
        exp_q.push_back(4'hD);
        for (int k = 0; k < 8; k++)
            exp_q.push_back(4'hF);
        bus.d = 8'h55;
        bus.d_valid = 1'b1;
        @(negedge clk);
        chk("idle d_ready with d_valid", {31'd0, bus.d_ready}, 32'd0);
        @(posedge clk);
        #1;
        bus.d_valid = 1'b0;
        wait_idle();
        chk("sfd starve tx_en clks", last_en_len, 24);
        chk("sfd starve underrun", under_cnt - u0, 1);
        chk("sfd starve frame_done", done_cnt - d0, 1);
        chk("sfd starve queue left", exp_q.size(), 0);

        // Back-to-back 64-byte frames with d_valid held.
        d0 = done_cnt;
        send_frame(3, 64, -1, -1);
        send_frame(3, 64, -1, -1);
        wait_idle();
        chk("b2b gap", gap, 24);
        chk("b2b frame_done", done_cnt - d0, 2);
        chk("b2b tx_en clks", last_en_len, 152);
        chk("b2b queue left", exp_q.size(), 0);

        // Reset after 20 payload bytes, then a clean frame.
        send_frame(1, 64, -1, 20);
        d0 = done_cnt;
        send_frame(0, 9, -1, -1);
        wait_idle();
        chk("post-rst frame_done", done_cnt - d0, 1);
        chk("post-rst queue left", exp_q.size(), 0);

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
